fp_divider_param: RTL and testbench

Iterative IEEE-754 floating-point divider parametrised in exponent and mantissa width, so one RTL source serves single (8/23) and half (5/10) precision. It is the multi-cycle divide unit of the floating-point arithmetic unit, beside the adder and multiplier. Relative to the fixed single-precision divider it adds:

- round-to-nearest-even rounding;
- separate exception flags;
- a Busy output;
- a guaranteed Ready pulse for every accepted operation, including special cases.

---
 rtl/fp_divider_param.sv | 189 ++++++++++++++++++
 tb/tb_fp_divider_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divider_param.sv
// Multi-cycle IEEE-754 divider, width-parametrised (8/23 single, 5/10 half).
// Restoring radix-2 iteration, round-to-nearest-even, flush-to-zero on both ends.
module fp_divider_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  input  logic                   En,
  output logic [EXP_W+MAN_W:0]   Result,
  output logic                   Ready,
  output logic                   Busy,
  output logic                   NaN,
  output logic                   Overflow,
  output logic                   Underflow,
  output logic                   DivByZero
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int N      = MAN_W + 4;
  localparam int CW     = $clog2(N);
  localparam int XW     = EXP_W + 2 + MAN_W;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX_I = (1 << EXP_W) - 1;

  localparam logic [EXP_W+1:0] BIAS_X   = BIAS[EXP_W+1:0];
  localparam logic [EXP_W+1:0] EMAX_X   = EMAX_I[EXP_W+1:0];
  localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
  localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0]     INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t             state;
  logic               sign_r;
  logic [EXP_W+1:0]   exp_r;
  logic [MAN_W+1:0]   rem;
  logic [MAN_W:0]     dvs;
  logic [N-1:0]       quo;
  logic [CW-1:0]      cnt;

  // Operand decode and special-case selection
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sgn;
  logic               spec, spec_nan, spec_dbz;
  logic [W-1:0]       spec_res;
  logic [EXP_W+1:0]   exp_init;

  always_comb begin
    ea       = A[W-2:MAN_W];
    eb       = B[W-2:MAN_W];
    fa       = A[MAN_W-1:0];
    fb       = B[MAN_W-1:0];
    sgn      = A[W-1] ^ B[W-1];
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (ea == '1) && (fa == '0);
    b_inf    = (eb == '1) && (fb == '0);
    a_nan    = (ea == '1) && (fa != '0);
    b_nan    = (eb == '1) && (fb != '0);
    exp_init = {2'b00, ea} - {2'b00, eb} + BIAS_X;
    spec     = 1'b1;
    spec_nan = 1'b0;
    spec_dbz = 1'b0;
    spec_res = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNAN;
      spec_nan = 1'b1;
    end else if (a_inf) begin
      spec_res = {sgn, INF_MAG};
    end else if (b_zero) begin
      spec_res = {sgn, INF_MAG};
      spec_dbz = 1'b1;
    end else if (b_inf || a_zero) begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end else begin
      spec = 1'b0;
    end
  end

  // One restoring step: subtract when the partial remainder covers the divisor
  logic               q_bit;
  logic [MAN_W+1:0]   diff, part, rem_nx;

  always_comb begin
    q_bit  = (rem >= {1'b0, dvs});
    diff   = rem - {1'b0, dvs};
    part   = q_bit ? diff : rem;
    rem_nx = part << 1;
  end

  // Normalisation drops the leading one; rounding is added to {exp,frac} so a
  // fraction carry-out lands in the exponent as significand 1.0, exponent+1.
  logic [N-2:0]       q_norm;
  logic [EXP_W+1:0]   e_norm, e_fin;
  logic [MAN_W-1:0]   frac, frac_fin;
  logic               guard, sticky, rnd, rnd_ovf, rnd_unf;
  logic [XW-1:0]      mag_ext;
  logic [W-1:0]       rnd_res;

  always_comb begin
    q_norm   = quo[N-1] ? quo[N-2:0] : {quo[N-3:0], 1'b0};
    e_norm   = quo[N-1] ? exp_r : exp_r - 1'b1;
    frac     = q_norm[N-2:3];
    guard    = q_norm[2];
    sticky   = (|q_norm[1:0]) | (|rem);
    rnd      = guard & (sticky | frac[0]);
    mag_ext  = {e_norm, frac} + {{(XW-1){1'b0}}, rnd};
    e_fin    = mag_ext[XW-1:MAN_W];
    frac_fin = mag_ext[MAN_W-1:0];
    rnd_ovf  = !e_fin[EXP_W+1] && (e_fin >= EMAX_X);
    rnd_unf  = e_fin[EXP_W+1] || (e_fin == '0);
    if (rnd_ovf)
      rnd_res = {sign_r, INF_MAG};
    else if (rnd_unf)
      rnd_res = {sign_r, {(W-1){1'b0}}};
    else
      rnd_res = {sign_r, e_fin[EXP_W-1:0], frac_fin};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      Result    <= '0;
      Ready     <= 1'b0;
      Busy      <= 1'b0;
      NaN       <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      DivByZero <= 1'b0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      rem       <= '0;
      dvs       <= '0;
      quo       <= '0;
      cnt       <= '0;
    end else begin
      Ready <= 1'b0;
      case (state)
        IDLE: begin
          if (En) begin
            Busy      <= 1'b1;
            NaN       <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            DivByZero <= 1'b0;
            sign_r    <= sgn;
            exp_r     <= exp_init;
            rem       <= {1'b0, 1'b1, fa};
            dvs       <= {1'b1, fb};
            quo       <= '0;
            cnt       <= '0;
            if (spec) begin
              Result    <= spec_res;
              NaN       <= spec_nan;
              DivByZero <= spec_dbz;
              state     <= DONE;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          quo <= {quo[N-2:0], q_bit};
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= ROUND;
        end
        ROUND: begin
          Result    <= rnd_res;
          Overflow  <= rnd_ovf;
          Underflow <= rnd_unf;
          state     <= DONE;
        end
        DONE: begin
          Ready <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_param.sv
// Scoreboard bench for fp_divider_param at single (8/23) and half (5/10) precision.
// Expected results come from directed constants or an exact integer-division model.
module tb_fp_divider_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a32, b32, r32;
  logic        en32, rdy32, bsy32, nan32, ovf32, unf32, dbz32;
  logic [15:0] a16, b16, r16;
  logic        en16, rdy16, bsy16, nan16, ovf16, unf16, dbz16;

  always #5 clk = ~clk;

  fp_divider_param dut32 (
    .clk(clk), .reset(reset), .A(a32), .B(b32), .En(en32),
    .Result(r32), .Ready(rdy32), .Busy(bsy32), .NaN(nan32),
    .Overflow(ovf32), .Underflow(unf32), .DivByZero(dbz32)
  );

  fp_divider_param #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .En(en16),
    .Result(r16), .Ready(rdy16), .Busy(bsy16), .NaN(nan16),
    .Overflow(ovf16), .Underflow(unf16), .DivByZero(dbz16)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  exp_t q32[$];
  exp_t q16[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Reference: flags are {NaN, Overflow, Underflow, DivByZero}
  function automatic void ref_div(input int ew, input int mw,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [3:0] fl,
                                  output int lat);
    longint emax, bias, fmask, ea, eb, fa, fb, sgn, ma, mb, e, num, sig, rem;
    longint inf_w, zero_w, nan_w;
    int     s;
    bit     az, ai, an, bz, bi, bn;
    emax   = (longint'(1) << ew) - 1;
    bias   = (longint'(1) << (ew - 1)) - 1;
    fmask  = (longint'(1) << mw) - 1;
    ea     = (longint'(a) >> mw) & emax;
    eb     = (longint'(b) >> mw) & emax;
    fa     = longint'(a) & fmask;
    fb     = longint'(b) & fmask;
    sgn    = ((longint'(a) ^ longint'(b)) >> (ew + mw)) & 1;
    inf_w  = (sgn << (ew + mw)) | (emax << mw);
    zero_w = sgn << (ew + mw);
    nan_w  = (emax << mw) | (longint'(1) << (mw - 1));
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == emax) && (fa == 0);
    bi = (eb == emax) && (fb == 0);
    an = (ea == emax) && (fa != 0);
    bn = (eb == emax) && (fb != 0);
    fl  = 4'b0000;
    lat = 1;
    if (an || bn || (az && bz) || (ai && bi)) begin
      res = 32'(nan_w);
      fl  = 4'b1000;
    end else if (ai) begin
      res = 32'(inf_w);
    end else if (bz) begin
      res = 32'(inf_w);
      fl  = 4'b0001;
    end else if (bi || az) begin
      res = 32'(zero_w);
    end else begin
      lat = mw + 6;
      ma  = fa | (longint'(1) << mw);
      mb  = fb | (longint'(1) << mw);
      e   = ea - eb + bias;
      s   = mw;
      if (ma < mb) begin
        s = mw + 1;
        e = e - 1;
      end
      num = ma << s;
      sig = num / mb;
      rem = num % mb;
      if ((2 * rem > mb) || ((2 * rem == mb) && ((sig & 1) == 1)))
        sig = sig + 1;
      if (sig == (longint'(1) << (mw + 1))) begin
        sig = sig >> 1;
        e   = e + 1;
      end
      if (e >= emax) begin
        res = 32'(inf_w);
        fl  = 4'b0100;
      end else if (e <= 0) begin
        res = 32'(zero_w);
        fl  = 4'b0010;
      end else begin
        res = 32'(zero_w | (e << mw) | (sig & fmask));
      end
    end
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int mw);
    int          emax;
    int          bias;
    int unsigned sel;
    logic [31:0] f, e, s;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    sel  = $urandom_range(0, 15);
    f    = $urandom & ((32'd1 << mw) - 32'd1);
    s    = 32'($urandom_range(0, 1));
    case (sel)
      0: begin e = '0; f = '0; end
      1: begin e = 32'(emax); f = '0; end
      2: begin e = 32'(emax); f = f | 32'd1; end
      3: begin e = '0; f = f | 32'd1; end
      4, 5, 6: e = 32'($urandom_range(1, emax - 1));
      default: e = 32'(bias - 6 + int'($urandom_range(0, 12)));
    endcase
    return (s << (ew + mw)) | (e << mw) | f;
  endfunction

  task automatic issue(input bit half, input logic [31:0] a, input logic [31:0] b,
                       input bit use_model, input logic [31:0] dres,
                       input logic [3:0] dfl, input int dlat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while ((half ? bsy16 : bsy32) !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got Busy=1 for 200 cycles expected release");
    end
    if (use_model) begin
      ref_div(half ? 5 : 8, half ? 10 : 23, a, b, e.res, e.fl, e.lat);
    end else begin
      e.res = dres;
      e.fl  = dfl;
      e.lat = dlat;
    end
    if (half) begin
      a16 = a[15:0]; b16 = b[15:0]; en16 = 1'b1;
    end else begin
      a32 = a; b32 = b; en32 = 1'b1;
    end
    @(posedge clk);
    #1;
    en16  = 1'b0;
    en32  = 1'b0;
    e.acc = cyc;
    chk(half ? "hp_busy_after_accept" : "sp_busy_after_accept",
        {31'b0, half ? bsy16 : bsy32}, 32'd1);
    if (half) q16.push_back(e);
    else      q32.push_back(e);
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (reset === 1'b1 && rdy32 === 1'b1) begin
      if (q32.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sp_unexpected_ready: got Ready=1 expected no pending operation");
      end else begin
        e = q32.pop_front();
        chk("sp_result", r32, e.res);
        chk("sp_flags", {28'b0, nan32, ovf32, unf32, dbz32}, {28'b0, e.fl});
        chk("sp_latency", cyc - e.acc, e.lat);
        chk("sp_busy_at_ready", {31'b0, bsy32}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (reset === 1'b1 && rdy16 === 1'b1) begin
      if (q16.size() == 0) begin
        total++;
        bad++;
        $display("FAIL hp_unexpected_ready: got Ready=1 expected no pending operation");
      end else begin
        e = q16.pop_front();
        chk("hp_result", {16'b0, r16}, e.res);
        chk("hp_flags", {28'b0, nan16, ovf16, unf16, dbz16}, {28'b0, e.fl});
        chk("hp_latency", cyc - e.acc, e.lat);
        chk("hp_busy_at_ready", {31'b0, bsy16}, 32'd0);
      end
    end
  end

  vec_t sp_v[10] = '{
    '{32'h40700000, 32'h3FC00000, 32'h40200000, 4'b0000, 29},
    '{32'hC0000000, 32'h3F400000, 32'hC02AAAAB, 4'b0000, 29},
    '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29},
    '{32'h40A00000, 32'h00000000, 32'h7F800000, 4'b0001, 1},
    '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1},
    '{32'h7FC00000, 32'h40000000, 32'h7FC00000, 4'b1000, 1},
    '{32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000, 1},
    '{32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 1},
    '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0100, 29},
    '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 4'b0010, 29}
  };

  vec_t hp_v[2] = '{
    '{32'h00003C00, 32'h00004200, 32'h00003555, 4'b0000, 16},
    '{32'h00007BFF, 32'h00003800, 32'h00007C00, 4'b0100, 16}
  };

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected completion within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int rdy_seen;
    reset = 1'b0;
    en32 = 1'b0; en16 = 1'b0;
    a32 = '0; b32 = '0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sp_reset_result", r32, 32'h0);
    chk("sp_reset_ctl", {26'b0, rdy32, bsy32, nan32, ovf32, unf32, dbz32}, 32'h0);
    chk("hp_reset_result", {16'b0, r16}, 32'h0);
    chk("hp_reset_ctl", {26'b0, rdy16, bsy16, nan16, ovf16, unf16, dbz16}, 32'h0);
    reset = 1'b1;

    foreach (sp_v[i])
      issue(1'b0, sp_v[i].a, sp_v[i].b, 1'b0, sp_v[i].res, sp_v[i].fl, sp_v[i].lat);
    foreach (hp_v[i])
      issue(1'b1, hp_v[i].a, hp_v[i].b, 1'b0, hp_v[i].res, hp_v[i].fl, hp_v[i].lat);

    // Late En with new operands while busy must be dropped
    issue(1'b0, 32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAB, 4'b0000, 29);
    repeat (4) @(posedge clk);
    @(negedge clk);
    a32 = 32'h40A00000; b32 = 32'h00000000; en32 = 1'b1;
    @(posedge clk);
    #1;
    en32 = 1'b0;
    a32 = $urandom; b32 = $urandom;
    chk("sp_busy_ignored_en", {31'b0, bsy32}, 32'd1);

    for (int i = 0; i < 60; i++)
      issue(1'b0, rand_op(8, 23), rand_op(8, 23), 1'b1, '0, '0, 0);
    for (int i = 0; i < 40; i++)
      issue(1'b1, rand_op(5, 10), rand_op(5, 10), 1'b1, '0, '0, 0);

    n = 0;
    while ((q32.size() != 0 || q16.size() != 0 || bsy32 || bsy16) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("sp_queue_drained", q32.size(), 32'd0);
    chk("hp_queue_drained", q16.size(), 32'd0);

    // Abort an operation mid-divide
    @(negedge clk);
    a32 = 32'h40700000; b32 = 32'h3FC00000; en32 = 1'b1;
    @(posedge clk);
    #1;
    en32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_result", r32, 32'h0);
    chk("abort_ctl", {26'b0, rdy32, bsy32, nan32, ovf32, unf32, dbz32}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rdy32) rdy_seen++;
    end
    chk("abort_no_ready", rdy_seen, 32'd0);
    chk("abort_idle_busy", {31'b0, bsy32}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
